// File: rtl/key_event_filter.sv
// key_event_filter: turns keypad_scan's bouncing level into one key_valid pulse per press
// and raises entry_clear after an idle timeout. Optional macro GLITCH_CNT_EN adds glitch_count.
module key_event_filter #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned TIMEOUT_CYCLES  = 625000000,
   parameter int unsigned CNT_W           = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_valid,
   input  logic [3:0] raw_code,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held,
   output logic       entry_clear
`ifdef GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_count
`endif
);

   if (DEBOUNCE_CYCLES < 2) begin : g_debounce_range
      $error("key_event_filter: DEBOUNCE_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {IDLE, PRESS_DEB, PRESSED, RELEASE_DEB} state_e;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic [3:0]       cand_q, cand_d;
   logic             armed_q, armed_d;
   logic             key_valid_q, key_valid_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_held_q, key_held_d;
   logic             entry_clear_q, entry_clear_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         tcnt_q        <= '0;
         cand_q        <= '0;
         armed_q       <= 1'b0;
         key_valid_q   <= 1'b0;
         key_code_q    <= '0;
         key_held_q    <= 1'b0;
         entry_clear_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tcnt_q        <= tcnt_d;
         cand_q        <= cand_d;
         armed_q       <= armed_d;
         key_valid_q   <= key_valid_d;
         key_code_q    <= key_code_d;
         key_held_q    <= key_held_d;
         entry_clear_q <= entry_clear_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:        if (raw_valid) state_d = PRESS_DEB;
         PRESS_DEB: begin
            if (!raw_valid || raw_code != cand_q) state_d = IDLE;
            else if (cnt_q >= DEB_LAST)           state_d = PRESSED;
         end
         PRESSED:     if (!raw_valid) state_d = RELEASE_DEB;
         RELEASE_DEB: begin
            if (raw_valid)              state_d = PRESSED;
            else if (cnt_q >= DEB_LAST) state_d = IDLE;
         end
         default:     state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d         = cnt_q;
      tcnt_d        = '0;
      cand_d        = cand_q;
      armed_d       = armed_q;
      key_valid_d   = 1'b0;
      key_code_d    = key_code_q;
      entry_clear_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A press sampled on the expiry edge suppresses the timeout.
            if (raw_valid) begin
               cand_d = raw_code;
               cnt_d  = CNT_W'(1);
            end else if (TMO_EN && armed_q && !key_valid_q) begin
               if (tcnt_q >= TMO_LAST) begin
                  entry_clear_d = 1'b1;
                  armed_d       = 1'b0;
               end else begin
                  tcnt_d = sat_inc(tcnt_q);
               end
            end
         end
         PRESS_DEB: begin
            if (!raw_valid || raw_code != cand_q) begin
               cnt_d = '0;
            end else begin
               cnt_d = sat_inc(cnt_q);
               if (cnt_q >= DEB_LAST) begin
                  key_code_d  = cand_q;
                  key_valid_d = 1'b1;
                  armed_d     = 1'b1;
               end
            end
         end
         PRESSED: if (!raw_valid) cnt_d = CNT_W'(1);
         RELEASE_DEB: begin
            if (raw_valid || cnt_q >= DEB_LAST) cnt_d = '0;
            else                                cnt_d = sat_inc(cnt_q);
         end
         default: cnt_d = '0;
      endcase
      key_held_d = (state_d == PRESSED) || (state_d == RELEASE_DEB);
   end

   assign key_valid   = key_valid_q;
   assign key_code    = key_code_q;
   assign key_held    = key_held_q;
   assign entry_clear = entry_clear_q;

`ifdef GLITCH_CNT_EN
   logic [7:0] glitch_q;
   logic       glitch_evt;

   assign glitch_evt = ((state_q == PRESS_DEB) && (state_d == IDLE)) ||
                       ((state_q == RELEASE_DEB) && (state_d == PRESSED));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      glitch_q <= '0;
      else if (glitch_evt && !(&glitch_q)) glitch_q <= glitch_q + 8'd1;
   end

   assign glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_key_event_filter.sv
// Bench for key_event_filter: directed scenarios plus random chatter against a run-length
// reference model of the debounce and idle-timeout rules.
module tb_key_event_filter;
   localparam int DB  = 4;
   localparam int TMO = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       raw_valid = 1'b0;
   logic [3:0] raw_code = 4'h0;
   logic       key_valid, key_held, entry_clear;
   logic [3:0] key_code;
`ifdef GLITCH_CNT_EN
   logic [7:0] glitch_count;
`endif

   int checks = 0;
   int errors = 0;

   // reference model: run lengths of stable samples and quiet idle edges
   bit         m_held, m_armed, m_kv, m_ec;
   int         m_run, m_low, m_quiet, m_glitch;
   logic [3:0] m_cand, m_code;

   key_event_filter #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TMO), .CNT_W(30)) dut (
      .clk(clk), .rst(rst), .raw_valid(raw_valid), .raw_code(raw_code),
      .key_valid(key_valid), .key_code(key_code), .key_held(key_held),
      .entry_clear(entry_clear)
`ifdef GLITCH_CNT_EN
      , .glitch_count(glitch_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_held = 0; m_armed = 0; m_kv = 0; m_ec = 0;
      m_run = 0; m_low = 0; m_quiet = 0; m_glitch = 0;
      m_cand = 4'h0; m_code = 4'h0;
   endtask

   task automatic model_edge(input logic v, input logic [3:0] c);
      m_kv = 0; m_ec = 0;
      if (!m_held) begin
         if (m_run == 0) begin
            if (v) begin
               m_run = 1; m_cand = c; m_quiet = 0;
            end else if (m_armed) begin
               m_quiet++;
               if (m_quiet == TMO) begin m_ec = 1; m_armed = 0; m_quiet = 0; end
            end else m_quiet = 0;
         end else if (v && c == m_cand) begin
            m_run++;
            if (m_run == DB) begin
               m_kv = 1; m_code = m_cand; m_held = 1; m_armed = 1; m_run = 0; m_low = 0;
            end
         end else begin
            m_run = 0; m_quiet = 0;
            if (m_glitch < 255) m_glitch++;
         end
      end else begin
         if (v) begin
            if (m_low > 0 && m_glitch < 255) m_glitch++;
            m_low = 0;
         end else begin
            m_low++;
            if (m_low == DB) begin m_held = 0; m_low = 0; end
         end
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic v, input logic [3:0] c);
      raw_valid = v; raw_code = c;
      @(posedge clk);
      model_edge(v, c);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b0; raw_valid = 1'b0; raw_code = 4'h0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      raw_valid = 1'b0; raw_code = 4'h0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({key_valid, key_code, key_held, entry_clear} !== 7'b0) begin
         errors++;
         $display("FAIL reset_state: got %b want 0000000", {key_valid, key_code, key_held, entry_clear});
      end
`ifdef GLITCH_CNT_EN
      checks++;
      if (glitch_count !== 8'd0) begin
         errors++; $display("FAIL reset_glitch: got %0d want 0", glitch_count);
      end
`endif
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_clean_press();
      int pulses = 0, pulse_at = -1, held_cnt = 0;
      apply_reset();
      for (int i = 1; i <= 20; i++) begin
         step(i <= 10, 4'h5);
         checks++;
         if ({key_valid, key_code, key_held, entry_clear} !== {m_kv, m_code, m_held, m_ec}) begin
            errors++;
            $display("FAIL clean_press cyc %0d: got %b want %b", i,
                     {key_valid, key_code, key_held, entry_clear}, {m_kv, m_code, m_held, m_ec});
         end
         if (key_valid === 1'b1) begin pulses++; pulse_at = i; end
         if (key_held === 1'b1) held_cnt++;
      end
      checks++;
      if (pulses !== 1 || pulse_at !== DB) begin
         errors++; $display("FAIL clean_pulse: got %0d pulses at %0d want 1 at %0d", pulses, pulse_at, DB);
      end
      checks++;
      if (key_code !== 4'h5) begin errors++; $display("FAIL clean_code: got %h want 5", key_code); end
      checks++;
      if (held_cnt !== 10) begin errors++; $display("FAIL clean_held: got %0d cycles want 10", held_cnt); end
   endtask

   task automatic test_bounce();
      logic pat [0:16] = '{1,1,0,1,1,1,1,1,1,1,0,0,0,0,0,0,0};
      int pulses = 0, pulse_at = -1;
      apply_reset();
      for (int i = 0; i < 17; i++) begin
         step(pat[i], 4'h3);
         checks++;
         if ({key_valid, key_code, key_held, entry_clear} !== {m_kv, m_code, m_held, m_ec}) begin
            errors++;
            $display("FAIL bounce cyc %0d: got %b want %b", i + 1,
                     {key_valid, key_code, key_held, entry_clear}, {m_kv, m_code, m_held, m_ec});
         end
         if (key_valid === 1'b1) begin pulses++; pulse_at = i + 1; end
      end
      checks++;
      if (pulses !== 1 || pulse_at !== 7) begin
         errors++; $display("FAIL bounce_pulse: got %0d pulses at %0d want 1 at 7", pulses, pulse_at);
      end
`ifdef GLITCH_CNT_EN
      checks++;
      if (glitch_count !== 8'd1) begin errors++; $display("FAIL bounce_glitch: got %0d want 1", glitch_count); end
`endif
   endtask

   task automatic test_code_change();
      int pulses = 0;
      logic [3:0] pulse_code = 4'h0;
      apply_reset();
      for (int i = 1; i <= 16; i++) begin
         step(i <= 9, (i <= 3) ? 4'h2 : 4'h7);
         checks++;
         if ({key_valid, key_code, key_held, entry_clear} !== {m_kv, m_code, m_held, m_ec}) begin
            errors++;
            $display("FAIL code_change cyc %0d: got %b want %b", i,
                     {key_valid, key_code, key_held, entry_clear}, {m_kv, m_code, m_held, m_ec});
         end
         if (key_valid === 1'b1) begin pulses++; pulse_code = key_code; end
      end
      checks++;
      if (pulses !== 1 || pulse_code !== 4'h7) begin
         errors++; $display("FAIL code_change_pulse: got %0d pulses code %h want 1 code 7", pulses, pulse_code);
      end
   endtask

   task automatic test_timeout();
      int ec_cnt = 0, ec_at = -1;
      apply_reset();
      for (int i = 1; i <= 84; i++) begin
         step(i <= DB, 4'h1);
         checks++;
         if ({key_valid, key_code, key_held, entry_clear} !== {m_kv, m_code, m_held, m_ec}) begin
            errors++;
            $display("FAIL timeout cyc %0d: got %b want %b", i,
                     {key_valid, key_code, key_held, entry_clear}, {m_kv, m_code, m_held, m_ec});
         end
         if (entry_clear === 1'b1) begin ec_cnt++; ec_at = i; end
      end
      checks++;
      if (ec_cnt !== 1 || ec_at !== 2 * DB + TMO) begin
         errors++; $display("FAIL timeout_once: got %0d at %0d want 1 at %0d", ec_cnt, ec_at, 2 * DB + TMO);
      end
      apply_reset();
      ec_cnt = 0;
      for (int i = 1; i <= 60; i++) begin
         step(1'b0, 4'h0);
         if (entry_clear === 1'b1) ec_cnt++;
      end
      checks++;
      if (ec_cnt !== 0) begin errors++; $display("FAIL timeout_unarmed: got %0d pulses want 0", ec_cnt); end
   endtask

   task automatic test_press_on_expiry();
      int ec_early = 0, ec_at = -1, p9_at = -1;
      int expiry = 2 * DB + TMO;
      apply_reset();
      for (int i = 1; i <= 77; i++) begin
         if (i <= DB)                              step(1'b1, 4'h1);
         else if (i >= expiry && i < expiry + 10)  step(1'b1, 4'h9);
         else                                      step(1'b0, 4'h0);
         checks++;
         if ({key_valid, key_code, key_held, entry_clear} !== {m_kv, m_code, m_held, m_ec}) begin
            errors++;
            $display("FAIL expiry cyc %0d: got %b want %b", i,
                     {key_valid, key_code, key_held, entry_clear}, {m_kv, m_code, m_held, m_ec});
         end
         if (entry_clear === 1'b1) begin
            if (i <= expiry + 12) ec_early++;
            else ec_at = i;
         end
         if (key_valid === 1'b1 && key_code === 4'h9) p9_at = i;
      end
      checks++;
      if (ec_early !== 0) begin errors++; $display("FAIL expiry_suppressed: got %0d pulses want 0", ec_early); end
      checks++;
      if (p9_at !== expiry + DB - 1) begin
         errors++; $display("FAIL expiry_key9: got pulse at %0d want %0d", p9_at, expiry + DB - 1);
      end
      checks++;
      if (ec_at !== expiry + 13 + TMO) begin
         errors++; $display("FAIL expiry_rearm: got clear at %0d want %0d", ec_at, expiry + 13 + TMO);
      end
   endtask

   task automatic test_reset_mid_op();
      int pulse_at = -1;
      apply_reset();
      step(1'b1, 4'hA); step(1'b1, 4'hA);
      rst = 1'b0;
      #1;
      checks++;
      if ({key_valid, key_code, key_held, entry_clear} !== 7'b0) begin
         errors++; $display("FAIL rst_mid_deb: got %b want 0000000", {key_valid, key_code, key_held, entry_clear});
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int i = 1; i <= 6 && pulse_at < 0; i++) begin
         step(1'b1, 4'hA);
         checks++;
         if ({key_valid, key_code, key_held, entry_clear} !== {m_kv, m_code, m_held, m_ec}) begin
            errors++;
            $display("FAIL rst_redeb cyc %0d: got %b want %b", i,
                     {key_valid, key_code, key_held, entry_clear}, {m_kv, m_code, m_held, m_ec});
         end
         if (key_valid === 1'b1) pulse_at = i;
      end
      checks++;
      if (pulse_at !== DB) begin errors++; $display("FAIL rst_redeb_pulse: got %0d want %0d", pulse_at, DB); end
      // key_valid is high right now; the reset must cut the pulse
      rst = 1'b0;
      #1;
      checks++;
      if ({key_valid, key_code, key_held, entry_clear} !== 7'b0) begin
         errors++; $display("FAIL rst_mid_pulse: got %b want 0000000", {key_valid, key_code, key_held, entry_clear});
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      model_reset();
      pulse_at = -1;
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, 4'hA);
         if (key_valid === 1'b1) pulse_at = i;
      end
      checks++;
      if (pulse_at !== DB || key_code !== 4'hA) begin
         errors++; $display("FAIL rst_pulse_repeat: got at %0d code %h want at %0d code a", pulse_at, key_code, DB);
      end
   endtask

   task automatic test_random();
      int len;
      logic v, vv;
      logic [3:0] c;
      apply_reset();
      for (int seg = 0; seg < 400; seg++) begin
         len = $urandom_range(1, 7);
         v = ($urandom_range(0, 2) != 0);
         c = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) begin v = 1'b0; len = $urandom_range(15, 30); end
         for (int j = 0; j < len; j++) begin
            vv = ($urandom_range(0, 9) == 0) ? ~v : v;
            step(vv, c);
            checks++;
            if ({key_valid, key_code, key_held, entry_clear} !== {m_kv, m_code, m_held, m_ec}) begin
               errors++;
               $display("FAIL random seg %0d: got %b want %b", seg,
                        {key_valid, key_code, key_held, entry_clear}, {m_kv, m_code, m_held, m_ec});
            end
`ifdef GLITCH_CNT_EN
            checks++;
            if (glitch_count !== 8'(m_glitch)) begin
               errors++; $display("FAIL random_glitch seg %0d: got %0d want %0d", seg, glitch_count, m_glitch);
            end
`endif
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_code_change();
      test_timeout();
      test_press_on_expiry();
      test_reset_mid_op();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
